capture_ram_writer: RTL and testbench
=====================================

Name: capture_ram_writer

Overview:
Parametrised successor to the single-word capture-to-RAM path. Takes one captured row (index + wide data + row_ready level) and writes it into line RAM as WORDS_PER_ROW consecutive narrower words, one per clock, at address row_index*WORDS_PER_ROW + k. Sits between the capture row assembler and the dual-port line RAM. Reports when it is busy and when a row is dropped.

Parameters:
ROW_WIDTH, 320, width of row_data in bits
WORD_WIDTH, 160, RAM data width; ROW_WIDTH must be an exact multiple (elaboration error otherwise)
INDEX_WIDTH, 8, width of row_index
ADDR_WIDTH, 9, RAM address width; must satisfy 2^ADDR_WIDTH >= 2^INDEX_WIDTH * WORDS_PER_ROW
(derived, localparam) WORDS_PER_ROW = ROW_WIDTH/WORD_WIDTH, range 1..16

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
row_index  in  INDEX_WIDTH  row number of row_data
row_data  in  ROW_WIDTH  captured row; bits [ROW_WIDTH-1 -: WORD_WIDTH] are word 0
row_ready  in  1  level; row_index/row_data valid while high
ram_address  out  ADDR_WIDTH  RAM write address
ram_data  out  WORD_WIDTH  RAM write data
write_enable  out  1  RAM write strobe, one word per cycle
busy  out  1  high while in WRITE
overrun  out  1  one-cycle pulse when a row is dropped

Behaviour:
- Reset (rst_n low, async): state=IDLE, ram_address=0, ram_data=0, write_enable=0, busy=0, overrun=0, row_ready_q=0, word counter=0.
- row_ready_q: row_ready registered each cycle; accept event = row_ready & ~row_ready_q (rising edge). A level held high across many cycles gives exactly one row write.
- IDLE: on accept, latch row_data and row_index into internal registers; at the same edge drive word 0: write_enable=1, ram_address=row_index*WORDS_PER_ROW, ram_data=word 0. Go to WRITE, counter=1. If WORDS_PER_ROW=1, return straight to IDLE (single-cycle write; busy never asserts).
- WRITE: busy=1. Each edge emits word k=counter from the latched row at latched_index*WORDS_PER_ROW+k and increments counter. After emitting word WORDS_PER_ROW-1, go to IDLE at the next edge, write_enable=0.
- Latency: first write strobe visible one cycle after row_ready rises (registered), then WORDS_PER_ROW consecutive strobes with no gaps.
- When write_enable=0, ram_address=0 and ram_data=0.
- Address arithmetic: index*WORDS_PER_ROW + k computed at ADDR_WIDTH, unsigned, no wrap under the parameter constraint.
- Overrun: an accept event while state=WRITE, including the cycle the last word is emitted, raises overrun for one cycle. The new row is dropped and the current row completes unchanged. An accept in IDLE is always taken.
- row_data/row_index changing during WRITE has no effect; the row is latched.
- Reset mid-WRITE: writes stop immediately; the partial row is not resumed.

Optional Feature:
CAPTURE_LSB_FIRST_EN: when defined, word 0 is row_data[WORD_WIDTH-1:0] and word k is bits [k*WORD_WIDTH +: WORD_WIDTH]. Address order is unchanged (k ascending). When undefined, the order is MSB-first as above.

Test Plan:
- Defaults: row_index=5, row_data={160'hA..A,160'h5..5}, row_ready rises and stays high for 10 cycles -> exactly two strobes on consecutive cycles: addr 10 data 160'hA..A, then addr 11 data 160'h5..5. busy high during the second word only; no further writes.
- Same stimulus with CAPTURE_LSB_FIRST_EN defined -> addr 10 data 160'h5..5, addr 11 data 160'hA..A.
- ROW_WIDTH=320, WORD_WIDTH=80, ADDR_WIDTH=10: index 255 -> addresses 1020..1023 in order, words MSB-first; write_enable low on the 5th cycle.
- Overrun: row_ready pulses high 1 cycle (index 3), low 1 cycle, high again during WRITE -> addrs 6,7 written from the first row, overrun=1 for one cycle, no writes for the second row.
- Back-to-back: second rising edge arrives the cycle after WRITE returns to IDLE -> accepted; writes follow with no overrun.
- Assert rst_n low during word 0 of a 4-word row -> all outputs 0 asynchronously. After release with row_ready still high, no write occurs until row_ready falls and rises again.

Source files
------------

// File: rtl/capture_ram_writer.sv
// capture_ram_writer: splits one captured row into WORDS_PER_ROW RAM words and
// writes them one per clock at row_index*WORDS_PER_ROW + k. Reports busy while
// words 1..N-1 are driven and pulses overrun when a row arrives mid-write.
// Optional macro CAPTURE_LSB_FIRST_EN: word 0 is taken from the row LSBs
// instead of the MSBs (address order unchanged).
module capture_ram_writer #(
   parameter int unsigned ROW_WIDTH   = 320,
   parameter int unsigned WORD_WIDTH  = 160,
   parameter int unsigned INDEX_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH  = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INDEX_WIDTH-1:0] row_index,
   input  logic [ROW_WIDTH-1:0]   row_data,
   input  logic                   row_ready,
   output logic [ADDR_WIDTH-1:0]  ram_address,
   output logic [WORD_WIDTH-1:0]  ram_data,
   output logic                   write_enable,
   output logic                   busy,
   output logic                   overrun
);

   localparam int unsigned WORDS_PER_ROW = ROW_WIDTH / WORD_WIDTH;
   localparam logic [4:0]  WPR_C         = 5'(WORDS_PER_ROW);

   // Parameter sanity checks at elaboration.
   if (ROW_WIDTH % WORD_WIDTH != 0) begin : g_bad_ratio
      $error("ROW_WIDTH must be an exact multiple of WORD_WIDTH");
   end
   if (WORDS_PER_ROW < 1 || WORDS_PER_ROW > 16) begin : g_bad_wpr
      $error("WORDS_PER_ROW must be in 1..16");
   end
   if ((64'd1 << INDEX_WIDTH) * WORDS_PER_ROW > (64'd1 << ADDR_WIDTH)) begin : g_bad_addr
      $error("ADDR_WIDTH too small for INDEX_WIDTH * WORDS_PER_ROW");
   end

   typedef enum logic [0:0] {IDLE, WRITE} state_e;

   state_e                 state_q, state_d;
   logic [4:0]             cnt_q, cnt_d;
   logic                   row_ready_q, row_ready_d;
   logic                   armed_q, armed_d;
   logic [ROW_WIDTH-1:0]   row_q, row_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;
   logic [ADDR_WIDTH-1:0]  ram_address_q, ram_address_d;
   logic [WORD_WIDTH-1:0]  ram_data_q, ram_data_d;
   logic                   write_enable_q, write_enable_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;
   logic                   accept;

   function automatic logic [WORD_WIDTH-1:0] word_at(input logic [ROW_WIDTH-1:0] row,
                                                     input logic [4:0] k);
      logic [ROW_WIDTH-1:0] sh;
`ifdef CAPTURE_LSB_FIRST_EN
      sh = row >> (32'(k) * WORD_WIDTH);
      return sh[WORD_WIDTH-1:0];
`else
      sh = row << (32'(k) * WORD_WIDTH);
      return sh[ROW_WIDTH-1 -: WORD_WIDTH];
`endif
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [INDEX_WIDTH-1:0] idx,
                                                     input logic [4:0] k);
      return ADDR_WIDTH'(idx) * ADDR_WIDTH'(WORDS_PER_ROW) + ADDR_WIDTH'(k);
   endfunction

   // Next-state, word sequencing and registered output values.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      row_d          = row_q;
      index_d        = index_q;
      row_ready_d    = row_ready;
      // armed_q stays low after reset until row_ready has been seen low, so a
      // level still high across reset release does not count as a new row.
      armed_d        = armed_q | ~row_ready;
      ram_address_d  = '0;
      ram_data_d     = '0;
      write_enable_d = 1'b0;
      busy_d         = 1'b0;
      overrun_d      = 1'b0;
      accept         = row_ready & ~row_ready_q & armed_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               row_d          = row_data;
               index_d        = row_index;
               write_enable_d = 1'b1;
               ram_address_d  = addr_of(row_index, 5'd0);
               ram_data_d     = word_at(row_data, 5'd0);
               if (WORDS_PER_ROW > 1) begin
                  state_d = WRITE;
                  cnt_d   = 5'd1;
               end
            end
         end
         WRITE: begin
            // WRITE also covers the cycle the last word sits on the bus; a new
            // row arriving then is still an overrun.
            overrun_d = accept;
            if (cnt_q < WPR_C) begin
               write_enable_d = 1'b1;
               busy_d         = 1'b1;
               ram_address_d  = addr_of(index_q, cnt_q);
               ram_data_d     = word_at(row_q, cnt_q);
               cnt_d          = cnt_q + 5'd1;
            end else begin
               state_d = IDLE;
               cnt_d   = 5'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 5'd0;
         end
      endcase
   end

   // State and output registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         row_ready_q    <= 1'b0;
         armed_q        <= 1'b0;
         row_q          <= '0;
         index_q        <= '0;
         ram_address_q  <= '0;
         ram_data_q     <= '0;
         write_enable_q <= 1'b0;
         busy_q         <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         row_ready_q    <= row_ready_d;
         armed_q        <= armed_d;
         row_q          <= row_d;
         index_q        <= index_d;
         ram_address_q  <= ram_address_d;
         ram_data_q     <= ram_data_d;
         write_enable_q <= write_enable_d;
         busy_q         <= busy_d;
         overrun_q      <= overrun_d;
      end
   end

   assign ram_address  = ram_address_q;
   assign ram_data     = ram_data_q;
   assign write_enable = write_enable_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_capture_ram_writer.sv
// Directed bench for capture_ram_writer: a 2-word default instance and a
// 4-word (80-bit word) instance sharing clock and reset.
module tb_capture_ram_writer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 2-word instance
   logic [7:0]   idx2;
   logic [319:0] dat2;
   logic         rr2;
   logic [8:0]   addr2;
   logic [159:0] wd2;
   logic         we2, busy2, ov2;

   // 4-word instance
   logic [7:0]   idx4;
   logic [319:0] dat4;
   logic         rr4;
   logic [9:0]   addr4;
   logic [79:0]  wd4;
   logic         we4, busy4, ov4;

   capture_ram_writer u_dut2 (
      .clk(clk), .rst_n(rst_n), .row_index(idx2), .row_data(dat2), .row_ready(rr2),
      .ram_address(addr2), .ram_data(wd2), .write_enable(we2), .busy(busy2), .overrun(ov2)
   );

   capture_ram_writer #(.ROW_WIDTH(320), .WORD_WIDTH(80), .INDEX_WIDTH(8), .ADDR_WIDTH(10)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .row_index(idx4), .row_data(dat4), .row_ready(rr4),
      .ram_address(addr4), .ram_data(wd4), .write_enable(we4), .busy(busy4), .overrun(ov4)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [159:0] wa, w5, e2w0, e2w1;
   logic [79:0]  q4 [4];
   logic [79:0]  e4 [4];
   logic [319:0] row2, row4;

   initial begin
      wa   = {40{4'hA}};
      w5   = {40{4'h5}};
      row2 = {wa, w5};
      q4[0] = {20{4'h1}};
      q4[1] = {20{4'h2}};
      q4[2] = {20{4'h3}};
      q4[3] = {20{4'h4}};
      row4 = {q4[0], q4[1], q4[2], q4[3]};
`ifdef CAPTURE_LSB_FIRST_EN
      e2w0 = w5;
      e2w1 = wa;
      for (int i = 0; i < 4; i++) e4[i] = q4[3-i];
`else
      e2w0 = wa;
      e2w1 = w5;
      for (int i = 0; i < 4; i++) e4[i] = q4[i];
`endif

      rst_n = 1'b0;
      rr2 = 1'b0; idx2 = '0; dat2 = '0;
      rr4 = 1'b0; idx4 = '0; dat4 = '0;
      #2;
      chk("rst_we2", 320'(we2), 320'(0));
      chk("rst_addr2", 320'(addr2), 320'(0));
      chk("rst_data2", 320'(wd2), 320'(0));
      chk("rst_busy2", 320'(busy2), 320'(0));
      chk("rst_ov2", 320'(ov2), 320'(0));
      chk("rst_we4", 320'(we4), 320'(0));
      #6 rst_n = 1'b1;
      step();
      step();

      // Basic 2-word row, level held for 10 cycles
      idx2 = 8'd5; dat2 = row2; rr2 = 1'b1;
      step();
      chk("t1_we0", 320'(we2), 320'(1));
      chk("t1_addr0", 320'(addr2), 320'(10));
      chk("t1_data0", 320'(wd2), 320'(e2w0));
      chk("t1_busy0", 320'(busy2), 320'(0));
      step();
      chk("t1_we1", 320'(we2), 320'(1));
      chk("t1_addr1", 320'(addr2), 320'(11));
      chk("t1_data1", 320'(wd2), 320'(e2w1));
      chk("t1_busy1", 320'(busy2), 320'(1));
      step();
      chk("t1_we_end", 320'(we2), 320'(0));
      chk("t1_addr_end", 320'(addr2), 320'(0));
      chk("t1_data_end", 320'(wd2), 320'(0));
      chk("t1_busy_end", 320'(busy2), 320'(0));
      for (int i = 0; i < 7; i++) begin
         step();
         chk("t1_no_rewrite", 320'(we2), 320'(0));
      end
      rr2 = 1'b0;
      step();

      // 4-word row at the top index
      idx4 = 8'd255; dat4 = row4; rr4 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t4_we", 320'(we4), 320'(1));
         chk("t4_addr", 320'(addr4), 320'(1020 + k));
         chk("t4_data", 320'(wd4), 320'(e4[k]));
         chk("t4_busy", 320'(busy4), 320'(k != 0));
      end
      step();
      chk("t4_we_5th", 320'(we4), 320'(0));
      rr4 = 1'b0;
      step();

      // Overrun: second rising edge while the first row is still in WRITE
      idx2 = 8'd3; dat2 = row2; rr2 = 1'b1;
      step();
      chk("ov_addr0", 320'(addr2), 320'(6));
      chk("ov_data0", 320'(wd2), 320'(e2w0));
      rr2 = 1'b0; idx2 = 8'd9; dat2 = ~row2;
      step();
      chk("ov_addr1", 320'(addr2), 320'(7));
      chk("ov_data1", 320'(wd2), 320'(e2w1));
      chk("ov_flag_pre", 320'(ov2), 320'(0));
      rr2 = 1'b1;
      step();
      chk("ov_flag", 320'(ov2), 320'(1));
      chk("ov_no_write", 320'(we2), 320'(0));
      step();
      chk("ov_flag_clear", 320'(ov2), 320'(0));
      chk("ov_dropped", 320'(we2), 320'(0));
      rr2 = 1'b0;
      step();

      // Back-to-back: new edge on the first IDLE cycle is taken
      idx2 = 8'd1; dat2 = row2; rr2 = 1'b1;
      step();
      chk("b2b_addr0", 320'(addr2), 320'(2));
      rr2 = 1'b0;
      step();
      chk("b2b_addr1", 320'(addr2), 320'(3));
      step();
      chk("b2b_gap", 320'(we2), 320'(0));
      idx2 = 8'd7; rr2 = 1'b1;
      step();
      chk("b2b2_we0", 320'(we2), 320'(1));
      chk("b2b2_addr0", 320'(addr2), 320'(14));
      chk("b2b2_ov", 320'(ov2), 320'(0));
      step();
      chk("b2b2_addr1", 320'(addr2), 320'(15));
      chk("b2b2_data1", 320'(wd2), 320'(e2w1));
      chk("b2b2_ov1", 320'(ov2), 320'(0));
      rr2 = 1'b0;
      step();
      step();

      // Reset during word 0 of a 4-word row
      idx4 = 8'd2; dat4 = row4; rr4 = 1'b1;
      step();
      chk("mr_we0", 320'(we4), 320'(1));
      chk("mr_addr0", 320'(addr4), 320'(8));
      #1 rst_n = 1'b0;
      #1;
      chk("mr_async_we", 320'(we4), 320'(0));
      chk("mr_async_addr", 320'(addr4), 320'(0));
      chk("mr_async_data", 320'(wd4), 320'(0));
      chk("mr_async_busy", 320'(busy4), 320'(0));
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mr_held_level", 320'(we4), 320'(0));
      end
      rr4 = 1'b0;
      step();
      chk("mr_low", 320'(we4), 320'(0));
      rr4 = 1'b1;
      step();
      chk("mr_rearm_we", 320'(we4), 320'(1));
      chk("mr_rearm_addr", 320'(addr4), 320'(8));
      chk("mr_rearm_data", 320'(wd4), 320'(e4[0]));
      for (int k = 1; k < 4; k++) begin
         step();
         chk("mr_rearm_seq", 320'(addr4), 320'(8 + k));
      end
      rr4 = 1'b0;
      step();
      chk("mr_done", 320'(we4), 320'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
